bh_serial_adder: RTL

//  Parametrised digit-serial adder/subtractor. Sums two WIDTH-bit operands DIGIT_W bits per clock.

---
 rtl/bh_adder_pkg.sv | 15 +
 rtl/bh_digit_adder.sv | 22 ++
 rtl/bh_serial_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/bh_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and digit-count helper.
// No logic, no latency, no flow control.
package bh_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width, input int digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/bh_digit_adder.sv
// Combinational DIGIT_W-bit adder slice: digit sum, carry out, and carry into the top bit.
// Zero latency; no backpressure.
module bh_digit_adder #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a_dig_i,
    input  logic [DIGIT_W-1:0] b_dig_i,
    input  logic               c_i,
    output logic [DIGIT_W-1:0] sum_o,
    output logic               c_o,
    output logic               c_msb_o
);

    logic [DIGIT_W:0] full;

    assign full    = {1'b0, a_dig_i} + {1'b0, b_dig_i} + {{DIGIT_W{1'b0}}, c_i};
    assign sum_o   = full[DIGIT_W-1:0];
    assign c_o     = full[DIGIT_W];
    // Top sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb_o = a_dig_i[DIGIT_W-1] ^ b_dig_i[DIGIT_W-1] ^ full[DIGIT_W-1];

endmodule

// File: rtl/bh_serial_adder.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT_W bits per clock, LSB digit first.
// Latency: start at edge k -> done in cycle k+N+1; start is ignored while busy (no queueing).
module bh_serial_adder
    import bh_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = digit_count(WIDTH, DIGIT_W);
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH % DIGIT_W != 0) begin : g_bad_digit_w
            $error("bh_serial_adder: WIDTH must be a multiple of DIGIT_W");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic               load;
    logic [DIGIT_W-1:0] dig_sum;
    logic               dig_c, dig_c_msb;

    bh_digit_adder #(.DIGIT_W(DIGIT_W)) u_digit (
        .a_dig_i (a_q[DIGIT_W-1:0]),
        .b_dig_i (b_q[DIGIT_W-1:0]),
        .c_i     (c_q),
        .sum_o   (dig_sum),
        .c_o     (dig_c),
        .c_msb_o (dig_c_msb)
    );

    assign load = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    // Subtraction is a + ~b + ~cin: borrow-in becomes an inverted carry-in.
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_q >> DIGIT_W;
                b_d    = b_q >> DIGIT_W;
                c_d    = dig_c;
                sum_d  = WIDTH'({dig_sum, sum_q} >> DIGIT_W);
                cout_d = dig_c;
                ovf_d  = dig_c ^ dig_c_msb;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
